// File: rtl/temporizador_lavagem.sv
// Button debounce/start pulse, hysteretic drum-level flag and agitate/spin phase timer
// feeding the washing-machine controller. Optional timer freeze input under MAQ_TEMPO_PAUSA_EN.
module temporizador_lavagem #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int NIVEL_CHEIO     = 200,
    parameter int HISTERESE       = 8,
    parameter int LARGURA         = 16,
    parameter int T_AGITAR        = 1000,
    parameter int T_GIRAR         = 500
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               botao,
    input  logic [7:0]         nivel,
    input  logic [1:0]         estado_atual,
`ifdef MAQ_TEMPO_PAUSA_EN
    input  logic               pausa,
`endif
    output logic               inicio,
    output logic               cheio,
    output logic               tempo,
    output logic               secar,
    output logic [LARGURA-1:0] restante
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0]      DEB_MAX   = CW'(DEBOUNCE_CICLOS);
    localparam logic [7:0]         LIM_SET   = 8'(NIVEL_CHEIO);
    localparam logic [7:0]         LIM_CLR   = 8'(NIVEL_CHEIO - HISTERESE);
    localparam logic [LARGURA-1:0] CARGA_AG  = LARGURA'(T_AGITAR);
    localparam logic [LARGURA-1:0] CARGA_GIR = LARGURA'(T_GIRAR);

    localparam logic [1:0] ST_AGITAR = 2'd2;
    localparam logic [1:0] ST_GIRAR  = 2'd3;

    logic               sinc1, sinc2;
    logic               deb_nivel;
    logic [CW-1:0]      deb_cnt;
    logic [LARGURA-1:0] cont;
    logic [1:0]         estado_ant;
    logic               congela;
    logic               difere, aceita;
    logic [LARGURA-1:0] carga;

`ifdef MAQ_TEMPO_PAUSA_EN
    assign congela = pausa;
`else
    assign congela = 1'b0;
`endif

    // A change is accepted on the cycle after the counter has seen DEBOUNCE_CICLOS mismatches.
    assign difere = sinc2 ^ deb_nivel;
    assign aceita = difere && (deb_cnt == DEB_MAX);

    always_comb begin
        carga = '0;
        case (estado_atual)
            ST_AGITAR: carga = CARGA_AG;
            ST_GIRAR:  carga = CARGA_GIR;
            default:   carga = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sinc1      <= 1'b0;
            sinc2      <= 1'b0;
            deb_nivel  <= 1'b0;
            deb_cnt    <= '0;
            inicio     <= 1'b0;
            cheio      <= 1'b0;
            cont       <= '0;
            estado_ant <= 2'd0;
        end else begin
            sinc1 <= botao;
            sinc2 <= sinc1;

            if (!difere) begin
                deb_cnt <= '0;
            end else if (aceita) begin
                deb_nivel <= ~deb_nivel;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // Rising edges outside esperar are dropped, never queued.
            inicio <= aceita && !deb_nivel && (estado_atual == 2'd0) && !congela;

            if (nivel >= LIM_SET)
                cheio <= 1'b1;
            else if (nivel < LIM_CLR)
                cheio <= 1'b0;

            if (!congela) begin
                estado_ant <= estado_atual;
                if (estado_atual != estado_ant)
                    cont <= carga;
                else if (cont != '0)
                    cont <= cont - 1'b1;
            end
        end
    end

    assign restante = cont;
    assign tempo    = (estado_ant == ST_AGITAR) && (cont == '0);
    // Combinational on estado_atual so spin is reported from the very first girar cycle.
    assign secar    = (estado_atual == ST_GIRAR) && !((estado_ant == ST_GIRAR) && (cont == '0));

endmodule

// File: tb/tb_temporizador_lavagem.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops and compares.
module tb_temporizador_lavagem;
    localparam int D  = 4;
    localparam int NC = 200;
    localparam int H  = 8;
    localparam int W  = 16;
    localparam int TA = 10;
    localparam int TG = 5;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         botao = 1'b0;
    logic         pausa = 1'b0;
    logic [7:0]   nivel = 8'd0;
    logic [1:0]   estado_atual = 2'd0;
    logic         inicio, cheio, tempo, secar;
    logic [W-1:0] restante;

    always #5 clock = ~clock;

    temporizador_lavagem #(
        .DEBOUNCE_CICLOS(D), .NIVEL_CHEIO(NC), .HISTERESE(H),
        .LARGURA(W), .T_AGITAR(TA), .T_GIRAR(TG)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .botao(botao),
        .nivel(nivel),
        .estado_atual(estado_atual),
`ifdef MAQ_TEMPO_PAUSA_EN
        .pausa(pausa),
`endif
        .inicio(inicio),
        .cheio(cheio),
        .tempo(tempo),
        .secar(secar),
        .restante(restante)
    );

    typedef struct {
        logic inicio;
        logic cheio;
        logic tempo;
        logic secar;
        int   restante;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: sampled-button delay line, run length of disagreeing samples,
    // and the phase timer as "loaded duration minus cycles elapsed since the load".
    logic m_s1, m_s2, m_deb, m_inicio, m_cheio;
    int   m_run, m_ant, m_load, m_load_cyc, m_cyc;

    initial begin
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_inicio = 0; m_cheio = 0;
        m_run = 0; m_ant = 0; m_load = 0; m_load_cyc = 0; m_cyc = 0;
    end

    function automatic int dur(input int e);
        return (e == 2) ? TA : (e == 3) ? TG : 0;
    endfunction

    function automatic int m_rest();
        int el;
        el = m_cyc - m_load_cyc;
        return (m_load > el) ? m_load - el : 0;
    endfunction

    task automatic model_edge();
        logic pz;
`ifdef MAQ_TEMPO_PAUSA_EN
        pz = pausa;
`else
        pz = 1'b0;
`endif
        m_cyc++;
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0; m_inicio = 0; m_cheio = 0;
            m_ant = 0; m_load = 0; m_load_cyc = m_cyc;
        end else begin
            m_inicio = 0;
            if (m_s2 != m_deb) begin
                if (m_run == D) begin
                    m_deb = m_s2;
                    m_run = 0;
                    m_inicio = m_s2 && (estado_atual == 2'd0) && !pz;
                end else begin
                    m_run++;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = botao;
            if (int'(nivel) >= NC)
                m_cheio = 1;
            else if (int'(nivel) < NC - H)
                m_cheio = 0;
            if (pz) begin
                m_load_cyc++;
            end else if (int'(estado_atual) != m_ant) begin
                m_ant = int'(estado_atual);
                m_load = dur(m_ant);
                m_load_cyc = m_cyc;
            end
        end
    endtask

    task automatic cyc(input logic b, input int n, input int e, input logic r, input logic p);
        exp_t x;
        @(posedge clock);
        model_edge();
        #2;
        botao = b;
        nivel = 8'(n);
        estado_atual = 2'(e);
        reset_n = r;
        pausa = p;
        x.restante = m_rest();
        x.inicio = m_inicio;
        x.cheio = m_cheio;
        x.tempo = (m_ant == 2) && (x.restante == 0);
        x.secar = (e == 3) && !((m_ant == 3) && (x.restante == 0));
        q.push_back(x);
    endtask

    task automatic hold(input logic b, input int n, input int e, input int c);
        for (int i = 0; i < c; i++) cyc(b, n, e, 1'b1, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %0d, expected %0d", vectors, nm, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("inicio", 32'(inicio), 32'(e.inicio));
                chk("cheio", 32'(cheio), 32'(e.cheio));
                chk("tempo", 32'(tempo), 32'(e.tempo));
                chk("secar", 32'(secar), 32'(e.secar));
                chk("restante", 32'(restante), 32'(e.restante));
            end
        end
    end

    initial begin
        int st, len, b, n, p;
        cyc(1'b0, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        hold(1'b0, 0, 0, 3);

        // Glitch of 3 cycles, then a held press and release in esperar
        hold(1'b1, 0, 0, 3);
        hold(1'b0, 0, 0, 8);
        hold(1'b1, 0, 0, 14);
        hold(1'b0, 0, 0, 10);

        // Press while agitar, back to esperar still held
        hold(1'b1, 0, 2, 12);
        hold(1'b1, 0, 0, 10);
        hold(1'b0, 0, 0, 10);

        // Level ramp across the hysteresis band
        hold(1'b0, 190, 0, 2);
        hold(1'b0, 205, 0, 2);
        hold(1'b0, 195, 0, 2);
        hold(1'b0, 192, 0, 2);
        hold(1'b0, 191, 0, 2);
        hold(1'b0, 192, 0, 2);

        // Full agitate, then full spin, then back to esperar
        hold(1'b0, 0, 1, 2);
        hold(1'b0, 0, 2, 15);
        hold(1'b0, 0, 3, 9);
        hold(1'b0, 0, 0, 3);

        // Spin aborted after 3 cycles
        hold(1'b0, 0, 2, 3);
        hold(1'b0, 0, 3, 3);
        hold(1'b0, 0, 0, 3);

        // Reset mid-agitate
        hold(1'b0, 0, 2, 4);
        cyc(1'b0, 0, 2, 1'b0, 1'b0);
        hold(1'b0, 0, 2, 14);
        hold(1'b0, 0, 0, 2);

        // Randomized segments
        b = 0;
        for (int s = 0; s < 60; s++) begin
            st = $urandom_range(3, 0);
            len = $urandom_range(14, 1);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(7, 0) == 0) b = 1 - b;
                n = $urandom_range(210, 185);
                p = ($urandom_range(9, 0) == 0) ? 1 : 0;
                cyc(1'(b), n, st, ($urandom_range(199, 0) != 0), 1'(p));
            end
        end
        hold(1'b0, 0, 0, 2);

        repeat (3) @(negedge clock);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
